// File: rtl/ai_link_pkg.sv
// Shared definitions for the UART <-> AI command bridge: state encodings,
// default framing bytes, fixed phase lengths and a byte-wise XOR helper.
package ai_link_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RECV      = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_WAIT_AI   = 3'd3;
    localparam state_t ST_SEND      = 3'd4;
    localparam state_t ST_SEND_WAIT = 3'd5;
    localparam state_t ST_AIRST     = 3'd6;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_RST_BYTE  = 8'h5A;

    // Length of the AI reset pulse and of the post-start transmitter guard
    localparam logic [2:0] AIRST_CYC    = 3'd4;
    localparam logic [2:0] TX_GUARD_CYC = 3'd2;

    // XOR of the lowest n bytes of a word (n up to 16)
    function automatic logic [7:0] xor_bytes(input logic [127:0] w, input int n);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i < n) acc = acc ^ w[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/ai_uart_bridge_if.sv
// Bundle of the byte-link and AI-core signals seen by the bridge.
// master: the bridge itself; slave: the UART/AI environment around it.
interface ai_uart_bridge_if #(
    parameter int RX_BYTES = 8,
    parameter int TX_BYTES = 8
);
    logic [7:0]            iRXD_DATA;
    logic                  iRXD_Ready;
    logic [7:0]            oTXD_DATA;
    logic                  oTXD_Start;
    logic                  iTXD_Done;
    logic [8*RX_BYTES-1:0] oAI_DATA;
    logic                  oAI_Start;
    logic [8*TX_BYTES-1:0] iAI_DATA;
    logic                  iAI_Done;
    logic                  oAI_RSTn;
    logic                  oBUSY;
    logic                  oERR;

    modport master (
        input  iRXD_DATA, iRXD_Ready, iTXD_Done, iAI_DATA, iAI_Done,
        output oTXD_DATA, oTXD_Start, oAI_DATA, oAI_Start, oAI_RSTn, oBUSY, oERR
    );

    modport slave (
        output iRXD_DATA, iRXD_Ready, iTXD_Done, iAI_DATA, iAI_Done,
        input  oTXD_DATA, oTXD_Start, oAI_DATA, oAI_Start, oAI_RSTn, oBUSY, oERR
    );
endinterface

// File: rtl/ai_link_timeout.sv
// Saturating cycle counter with synchronous clear; expired is high while
// the count sits at LIMIT. Used for both the inter-byte timeout and the
// AI watchdog.
module ai_link_timeout #(
    parameter int LIMIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != LIM))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LIM);

endmodule

// File: rtl/ai_uart_bridge.sv
// Command bridge between the RS232 byte link and the AI core: collects a
// sync-framed command, starts the AI, waits with a watchdog, and streams
// the result back MSB byte first. Build option AI_UART_BRIDGE_CKSUM_EN adds
// a trailing XOR byte to both the command frame and the reply.
module ai_uart_bridge
    import ai_link_pkg::*;
#(
    parameter int         RX_BYTES    = 8,
    parameter int         TX_BYTES    = 8,
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter logic [7:0] RST_BYTE    = DEF_RST_BYTE,
    parameter int         BYTE_TO_CYC = 2700000,
    parameter int         AI_TO_CYC   = 270000000
) (
    input logic              iCLK,
    input logic              iRST_n,
    ai_uart_bridge_if.master bus
);
    localparam int AI_W = 8 * RX_BYTES;
    localparam int TX_W = 8 * TX_BYTES;
`ifdef AI_UART_BRIDGE_CKSUM_EN
    localparam int CK = 1;
    localparam logic [4:0] RX_CK_IDX = 5'(RX_BYTES);
    localparam logic [4:0] TX_CK_IDX = 5'(TX_BYTES);
`else
    localparam int CK = 0;
    localparam logic [4:0] RX_LAST = 5'(RX_BYTES - 1);
`endif
    localparam logic [4:0] TX_LAST = 5'(TX_BYTES - 1 + CK);

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      ph_q, ph_d;
    logic [AI_W-1:0] ai_data_q, ai_data_d;
    logic [TX_W-1:0] tx_sr_q, tx_sr_d;
    logic            err_q, err_d;
    logic            byte_exp, ai_exp;
    logic            rx;
`ifdef AI_UART_BRIDGE_CKSUM_EN
    logic [7:0]      rx_ck_q, rx_ck_d;
    logic [7:0]      tx_ck_q, tx_ck_d;
`endif

    assign rx = bus.iRXD_Ready;

    ai_link_timeout #(.LIMIT(BYTE_TO_CYC)) u_byte_to (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .clr     ((state_q != ST_RECV) || rx),
        .en      (state_q == ST_RECV),
        .expired (byte_exp)
    );

    ai_link_timeout #(.LIMIT(AI_TO_CYC)) u_ai_wdog (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .clr     (state_q != ST_WAIT_AI),
        .en      (state_q == ST_WAIT_AI),
        .expired (ai_exp)
    );

    // Frame/move sequencer: next state, counters, shift registers, error pulse
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        ai_data_d = ai_data_q;
        tx_sr_d   = tx_sr_q;
        err_d     = 1'b0;
`ifdef AI_UART_BRIDGE_CKSUM_EN
        rx_ck_d   = rx_ck_q;
        tx_ck_d   = tx_ck_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx) begin
                    if (bus.iRXD_DATA == SYNC_BYTE) begin
                        state_d = ST_RECV;
                        cnt_d   = 5'd0;
`ifdef AI_UART_BRIDGE_CKSUM_EN
                        rx_ck_d = 8'h00;
`endif
                    end else if (bus.iRXD_DATA == RST_BYTE) begin
                        state_d = ST_AIRST;
                        ph_d    = 3'd0;
                    end
                end
            end
            ST_RECV: begin
                if (rx) begin
                    cnt_d = cnt_q + 5'd1;
`ifdef AI_UART_BRIDGE_CKSUM_EN
                    if (cnt_q == RX_CK_IDX) begin
                        if (bus.iRXD_DATA == rx_ck_q) begin
                            state_d = ST_START;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ai_data_d = AI_W'({ai_data_q, bus.iRXD_DATA});
                        rx_ck_d   = rx_ck_q ^ bus.iRXD_DATA;
                    end
`else
                    ai_data_d = AI_W'({ai_data_q, bus.iRXD_DATA});
                    if (cnt_q == RX_LAST)
                        state_d = ST_START;
`endif
                end else if (byte_exp) begin
                    // Partial command stays visible on oAI_DATA
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_AI;
                ph_d    = 3'd0;
            end
            ST_WAIT_AI: begin
                // First cycle skipped: done may still be high from the last move
                if (ph_q == 3'd0) begin
                    ph_d = 3'd1;
                end else if (bus.iAI_Done) begin
                    tx_sr_d = bus.iAI_DATA;
`ifdef AI_UART_BRIDGE_CKSUM_EN
                    tx_ck_d = xor_bytes(128'(bus.iAI_DATA), TX_BYTES);
`endif
                    cnt_d   = 5'd0;
                    state_d = ST_SEND;
                end else if (ai_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_AIRST;
                    ph_d    = 3'd0;
                end
            end
            ST_SEND: begin
                state_d = ST_SEND_WAIT;
                ph_d    = 3'd0;
            end
            ST_SEND_WAIT: begin
                // Guard lets the transmitter drop its done level after the start
                if (ph_q < TX_GUARD_CYC) begin
                    ph_d = ph_q + 3'd1;
                end else if (bus.iTXD_Done) begin
                    tx_sr_d = TX_W'({tx_sr_q, 8'h00});
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == TX_LAST) ? ST_IDLE : ST_SEND;
                end
            end
            ST_AIRST: begin
                if (ph_q == AIRST_CYC - 3'd1)
                    state_d = ST_IDLE;
                else
                    ph_d = ph_q + 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bytes arriving while a move is in flight are dropped as overruns
        if (rx && (state_q inside {ST_START, ST_WAIT_AI, ST_SEND, ST_SEND_WAIT, ST_AIRST}))
            err_d = 1'b1;
    end

    // State and datapath registers, all cleared by synchronous reset
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            ph_q      <= 3'd0;
            ai_data_q <= '0;
            tx_sr_q   <= '0;
            err_q     <= 1'b0;
`ifdef AI_UART_BRIDGE_CKSUM_EN
            rx_ck_q   <= 8'h00;
            tx_ck_q   <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            ai_data_q <= ai_data_d;
            tx_sr_q   <= tx_sr_d;
            err_q     <= err_d;
`ifdef AI_UART_BRIDGE_CKSUM_EN
            rx_ck_q   <= rx_ck_d;
            tx_ck_q   <= tx_ck_d;
`endif
        end
    end

    assign bus.oAI_DATA   = ai_data_q;
    assign bus.oAI_Start  = (state_q == ST_START);
    assign bus.oTXD_Start = (state_q == ST_SEND);
    assign bus.oAI_RSTn   = (state_q != ST_AIRST);
    assign bus.oBUSY      = (state_q != ST_IDLE);
    assign bus.oERR       = err_q;
`ifdef AI_UART_BRIDGE_CKSUM_EN
    assign bus.oTXD_DATA  = (cnt_q == TX_CK_IDX) ? tx_ck_q : tx_sr_q[TX_W-1 -: 8];
`else
    assign bus.oTXD_DATA  = tx_sr_q[TX_W-1 -: 8];
`endif

endmodule

// File: tb/tb_ai_uart_bridge.sv
// Self-checking bench for ai_uart_bridge: the bench plays the UART
// transmitter and the AI core, predicts commands and reply bytes at the
// transaction level, and checks them every cycle they appear.
module tb_ai_uart_bridge;
    localparam int RXB = 8;
    localparam int TXB = 8;
    localparam int BTO = 100;
    localparam int ATO = 200;
`ifdef AI_UART_BRIDGE_CKSUM_EN
    localparam int CKB = 1;
`else
    localparam int CKB = 0;
`endif

    logic clk;
    logic rst_n;

    ai_uart_bridge_if #(.RX_BYTES(RXB), .TX_BYTES(TXB)) bus ();

    ai_uart_bridge #(
        .RX_BYTES(RXB), .TX_BYTES(TXB), .SYNC_BYTE(8'hA5), .RST_BYTE(8'h5A),
        .BYTE_TO_CYC(BTO), .AI_TO_CYC(ATO)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_ai_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  tx_log[$];
    int tx_starts = 0;
    int ai_starts = 0;
    int err_cnt   = 0;
    int rst_run   = 0;
    int last_run  = 0;
    int ai_dn;
    int tx_dn;
    logic [63:0] ai_res;
    logic [63:0] pend_res;
    logic [7:0]  res_ck;

    bit          ai_hang   = 1'b0;
    int          ai_delay  = 10;
    bit          force_en  = 1'b0;
    logic [63:0] force_res = 64'h0;
    logic [7:0]  last_ck   = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired / unexpected event", name);
    endtask

    // Environment models and per-cycle compare of commands and reply bytes
    initial begin
        bus.iTXD_Done = 1'b1;
        bus.iAI_Done  = 1'b0;
        bus.iAI_DATA  = '0;
        ai_dn = -1;
        tx_dn = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_tx_q.delete();
                ai_dn = -1;
                tx_dn = 0;
                bus.iAI_Done  = 1'b0;
                bus.iTXD_Done = 1'b1;
                rst_run = 0;
            end else begin
                if (bus.oTXD_Start) begin
                    tx_starts++;
                    tx_log.push_back(bus.oTXD_DATA);
                    check("txd_start_when_idle", 64'(bus.iTXD_Done), 64'd1);
                    if (exp_tx_q.size() == 0)
                        fail_now("unexpected_txd_start");
                    else
                        check("txd_byte", 64'(bus.oTXD_DATA), 64'(exp_tx_q.pop_front()));
                    bus.iTXD_Done = 1'b0;
                    tx_dn = $urandom_range(1, 8);
                end else if (tx_dn > 0) begin
                    tx_dn--;
                    if (tx_dn == 0) bus.iTXD_Done = 1'b1;
                end

                if (bus.oAI_Start) begin
                    ai_starts++;
                    if (exp_ai_q.size() == 0)
                        fail_now("unexpected_ai_start");
                    else
                        check("ai_cmd", bus.oAI_DATA, exp_ai_q.pop_front());
                    bus.iAI_Done = 1'b0;
                    if (ai_hang) begin
                        ai_dn = -1;
                    end else begin
                        ai_res = force_en ? force_res : {$urandom, $urandom};
                        pend_res = ai_res;
                        res_ck = 8'h00;
                        for (int i = TXB - 1; i >= 0; i--) begin
                            exp_tx_q.push_back(ai_res[8*i +: 8]);
                            res_ck = res_ck ^ ai_res[8*i +: 8];
                        end
                        if (CKB != 0) exp_tx_q.push_back(res_ck);
                        ai_dn = ai_delay;
                    end
                end else if (ai_dn > 0) begin
                    ai_dn--;
                end else if (ai_dn == 0) begin
                    bus.iAI_DATA = pend_res;
                    bus.iAI_Done = 1'b1;
                    ai_dn = -1;
                end

                if (bus.oERR) err_cnt++;
                if (!bus.oAI_RSTn) begin
                    rst_run++;
                end else if (rst_run != 0) begin
                    last_run = rst_run;
                    rst_run = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.iRXD_DATA  = b;
        bus.iRXD_Ready = 1'b1;
        @(negedge clk);
        bus.iRXD_Ready = 1'b0;
    endtask

    task automatic gap(input int gmax);
        repeat ($urandom_range(0, gmax)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] cmd, input int gmax);
        logic [7:0] b;
        logic [7:0] ck;
        ck = 8'h00;
        exp_ai_q.push_back(cmd);
        send_byte(8'hA5);
        for (int i = RXB - 1; i >= 0; i--) begin
            gap(gmax);
            b  = cmd[8*i +: 8];
            ck = ck ^ b;
            send_byte(b);
        end
        last_ck = ck;
        if (CKB != 0) begin
            gap(gmax);
            send_byte(ck);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.oBUSY || exp_tx_q.size() != 0) && n < budget);
        if (bus.oBUSY || exp_tx_q.size() != 0) fail_now(name);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int tx0, err0, ai0, base, n;
    logic [63:0] cmd;
    logic [7:0]  junk;

    initial begin
        bus.iRXD_DATA  = 8'h00;
        bus.iRXD_Ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",    64'(bus.oBUSY),      64'd0);
        check("rst_ai_start",64'(bus.oAI_Start),  64'd0);
        check("rst_tx_start",64'(bus.oTXD_Start), 64'd0);
        check("rst_err",     64'(bus.oERR),       64'd0);
        check("rst_ai_rstn", 64'(bus.oAI_RSTn),   64'd1);
        check("rst_ai_data", bus.oAI_DATA,        64'd0);
        check("rst_txd_data",64'(bus.oTXD_DATA),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: known frame and known result
        tx0 = tx_starts; err0 = err_cnt; base = tx_log.size();
        force_en = 1'b1; force_res = 64'hDEADBEEF00112233; ai_delay = 12;
        send_frame(64'h0102030405060708, 3);
        wait_idle("t1_idle", 1500);
        force_en = 1'b0;
        check("t1_ai_data_hold", bus.oAI_DATA, 64'h0102030405060708);
        check("t1_tx_count", 64'(tx_starts - tx0), 64'(TXB + CKB));
        check("t1_err", 64'(err_cnt - err0), 64'd0);
        if (tx_log.size() >= base + TXB) begin
            check("t1_byte0", 64'(tx_log[base]),     64'hDE);
            check("t1_byte3", 64'(tx_log[base + 3]), 64'hEF);
            check("t1_byte7", 64'(tx_log[base + 7]), 64'h33);
        end else begin
            fail_now("t1_tx_log_short");
        end
`ifdef AI_UART_BRIDGE_CKSUM_EN
        check("t6_rx_ck_model", 64'(last_ck), 64'h08);
        if (tx_log.size() >= base + TXB + 1)
            check("t6_tx_ck_byte", 64'(tx_log[base + 8]), 64'h22);
        else
            fail_now("t6_tx_log_short");
`endif

        // Test 2: inter-byte timeout leaves partial command
        err0 = err_cnt; ai0 = ai_starts;
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (90) @(negedge clk);
        check("t2_busy_before_to", 64'(bus.oBUSY), 64'd1);
        check("t2_err_before_to", 64'(err_cnt - err0), 64'd0);
        repeat (40) @(negedge clk);
        check("t2_err_once", 64'(err_cnt - err0), 64'd1);
        check("t2_idle", 64'(bus.oBUSY), 64'd0);
        check("t2_no_start", 64'(ai_starts - ai0), 64'd0);
        check("t2_partial", bus.oAI_DATA, 64'h0405060708112233);
        tx0 = tx_starts;
        send_frame({$urandom, $urandom}, 5);
        wait_idle("t2_next_frame", 1500);
        check("t2_next_tx_count", 64'(tx_starts - tx0), 64'(TXB + CKB));

        // Test 3: AI watchdog
        err0 = err_cnt; tx0 = tx_starts; last_run = 0; ai_hang = 1'b1;
        send_frame(64'hCAFEF00D12345678, 2);
        wait_idle("t3_idle", 1000);
        ai_hang = 1'b0;
        check("t3_err", 64'(err_cnt - err0), 64'd1);
        check("t3_rst_len", 64'(last_run), 64'd4);
        check("t3_no_tx", 64'(tx_starts - tx0), 64'd0);

        // Test 4: AI reset byte and an ignored byte
        err0 = err_cnt; tx0 = tx_starts; last_run = 0;
        send_byte(8'h5A);
        wait_idle("t4_idle", 50);
        check("t4_rst_len", 64'(last_run), 64'd4);
        check("t4_no_tx", 64'(tx_starts - tx0), 64'd0);
        check("t4_no_err", 64'(err_cnt - err0), 64'd0);
        ai0 = ai_starts; last_run = 0;
        send_byte(8'h33);
        repeat (3) @(negedge clk);
        check("t4_ignored_busy", 64'(bus.oBUSY), 64'd0);
        check("t4_ignored_err", 64'(err_cnt - err0), 64'd0);
        check("t4_ignored_rst", 64'(last_run), 64'd0);
        check("t4_ignored_start", 64'(ai_starts - ai0), 64'd0);

        // Test 5a: overrun byte during WAIT_AI
        err0 = err_cnt; tx0 = tx_starts; ai_delay = 40;
        send_frame({$urandom, $urandom}, 2);
        repeat (3) @(negedge clk);
        send_byte(8'h77);
        wait_idle("t5_idle", 1500);
        check("t5_overrun_err", 64'(err_cnt - err0), 64'd1);
        check("t5_tx_count", 64'(tx_starts - tx0), 64'(TXB + CKB));

        // Test 5b: reset in the middle of the reply
        tx0 = tx_starts; ai_delay = 5;
        send_frame({$urandom, $urandom}, 2);
        n = 0;
        while ((tx_starts - tx0) < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if ((tx_starts - tx0) < 3) fail_now("t5_reach_send");
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_busy",     64'(bus.oBUSY),      64'd0);
        check("t5_rst_tx_start", 64'(bus.oTXD_Start), 64'd0);
        check("t5_rst_ai_rstn",  64'(bus.oAI_RSTn),   64'd1);
        check("t5_rst_ai_data",  bus.oAI_DATA,        64'd0);
        check("t5_rst_txd_data", 64'(bus.oTXD_DATA),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tx0 = tx_starts; ai0 = ai_starts;
        repeat (60) @(negedge clk);
        check("t5_no_tx_after_rst", 64'(tx_starts - tx0), 64'd0);
        check("t5_no_start_after_rst", 64'(ai_starts - ai0), 64'd0);
        check("t5_idle_after_rst", 64'(bus.oBUSY), 64'd0);

`ifdef AI_UART_BRIDGE_CKSUM_EN
        // Test 6: bad checksum is rejected
        err0 = err_cnt; ai0 = ai_starts;
        send_byte(8'hA5);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h00);
        repeat (5) @(negedge clk);
        check("t6_bad_ck_err", 64'(err_cnt - err0), 64'd1);
        check("t6_bad_ck_no_start", 64'(ai_starts - ai0), 64'd0);
        check("t6_bad_ck_idle", 64'(bus.oBUSY), 64'd0);
`endif

        // Randomized moves with junk bytes in IDLE
        for (int it = 0; it < 8; it++) begin
            junk = 8'($urandom);
            if (junk == 8'hA5 || junk == 8'h5A) junk = 8'h33;
            err0 = err_cnt;
            send_byte(junk);
            repeat (2) @(negedge clk);
            check("rnd_junk_idle", 64'(bus.oBUSY), 64'd0);
            tx0 = tx_starts;
            ai_delay = $urandom_range(2, 60);
            cmd = {$urandom, $urandom};
            send_frame(cmd, 12);
            wait_idle("rnd_idle", 2000);
            check("rnd_tx_count", 64'(tx_starts - tx0), 64'(TXB + CKB));
            check("rnd_no_err", 64'(err_cnt - err0), 64'd0);
            check("rnd_ai_data_hold", bus.oAI_DATA, cmd);
        end

        check("end_ai_queue_empty", 64'(exp_ai_q.size()), 64'd0);
        check("end_tx_queue_empty", 64'(exp_tx_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
